// File: rtl/spi_sched_pkg.sv
// Shared types for the SPI request scheduler: FSM states and the latched
// command that is presented to the SPI master's register-side inputs.
package spi_sched_pkg;

  localparam int MODE_W          = 2;
  localparam int SCHED_ADDR_BYTE = 1;
  localparam int SCHED_ADDR_W    = 8 * SCHED_ADDR_BYTE;

  typedef enum logic [1:0] {
    IDLE,
    START,
    BUSY,
    DONE
  } sched_state_t;

  // The address width tracks the scheduler's ADDR_BYTE, which must equal SCHED_ADDR_BYTE.
  typedef struct packed {
    logic [SCHED_ADDR_W-1:0] addr;
    logic [7:0]              data;
    logic [7:0]              num;
    logic [7:0]              slv;
    logic [MODE_W-1:0]       mode;
    logic                    wr;
  } spi_cmd_t;

endpackage

// File: rtl/spi_rr_arb.sv
// Combinational round-robin picker: returns the first set request at or
// after ptr, wrapping modulo REQ_NUM.
module spi_rr_arb #(
  parameter int REQ_NUM = 4,
  parameter int REQ_WTH = $clog2(REQ_NUM)
) (
  input  logic [REQ_NUM-1:0] req,
  input  logic [REQ_WTH-1:0] ptr,
  output logic [REQ_WTH-1:0] idx,
  output logic               any
);

  // Scan from the farthest slot back to ptr so the closest hit overwrites the rest.
  always_comb begin
    int slot;
    idx  = '0;
    any  = |req;
    slot = 0;
    for (int off = REQ_NUM - 1; off >= 0; off--) begin
      slot = int'(ptr) + off;
      if (slot >= REQ_NUM) slot = slot - REQ_NUM;
      if (req[REQ_WTH'(slot)]) idx = REQ_WTH'(slot);
    end
  end

endmodule

// File: rtl/spi_req_sched.sv
// Round-robin scheduler sharing one SPI master among REQ_NUM requesters:
// grant, trigger, wait for completion or timeout, then acknowledge.
module spi_req_sched
  import spi_sched_pkg::*;
#(
  parameter int REQ_NUM     = 4,
  parameter int ADDR_BYTE   = SCHED_ADDR_BYTE,
  parameter int TIMEOUT_CYC = 65535,
  parameter int REQ_WTH     = $clog2(REQ_NUM),
  parameter int TMO_WTH     = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [REQ_NUM-1:0]            req_vld,
  input  logic [REQ_NUM*8*ADDR_BYTE-1:0] req_addr,
  input  logic [REQ_NUM*8-1:0]          req_data,
  input  logic [REQ_NUM*8-1:0]          req_num,
  input  logic [REQ_NUM*8-1:0]          req_slv,
  input  logic [REQ_NUM*2-1:0]          req_mode,
  input  logic [REQ_NUM-1:0]            req_wr,
  output logic [REQ_NUM-1:0]            req_ack,
  output logic [7:0]                    rsp_data,
  output logic                          rsp_err,
  output logic [REQ_WTH-1:0]            gnt_idx,
  output logic                          busy,
  output logic                          spi_trg_start,
  output logic [8*ADDR_BYTE-1:0]        spi_address,
  output logic [7:0]                    spi_data,
  output logic [7:0]                    spi_data_num,
  output logic [7:0]                    spi_slv_sel,
  output logic [7:0]                    spi_mode,
  output logic                          spi_wr,
  input  logic                          spi_done,
  input  logic [7:0]                    spi_rdata
);

  sched_state_t       state;
  logic [REQ_WTH-1:0] ptr;
  logic [REQ_WTH-1:0] pick_idx;
  logic               pick_any;
  logic [TMO_WTH-1:0] tmo_cnt;
  spi_cmd_t           cmd_q;
  spi_cmd_t           cmd_arr [REQ_NUM];

  for (genvar i = 0; i < REQ_NUM; i++) begin : g_unpack
    assign cmd_arr[i] = {req_addr[i*8*ADDR_BYTE +: 8*ADDR_BYTE],
                         req_data[i*8 +: 8],
                         req_num[i*8 +: 8],
                         req_slv[i*8 +: 8],
                         req_mode[i*MODE_W +: MODE_W],
                         req_wr[i]};
  end

  spi_rr_arb #(
    .REQ_NUM (REQ_NUM),
    .REQ_WTH (REQ_WTH)
  ) u_arb (
    .req (req_vld),
    .ptr (ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Single FSM; trigger and ack default low so each is a one-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      ptr           <= '0;
      tmo_cnt       <= '0;
      cmd_q         <= '0;
      gnt_idx       <= '0;
      busy          <= 1'b0;
      spi_trg_start <= 1'b0;
      req_ack       <= '0;
      rsp_data      <= '0;
      rsp_err       <= 1'b0;
    end else begin
      spi_trg_start <= 1'b0;
      req_ack       <= '0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            cmd_q         <= cmd_arr[pick_idx];
            gnt_idx       <= pick_idx;
            busy          <= 1'b1;
            spi_trg_start <= 1'b1;
            state         <= START;
          end
        end
        START: begin
          tmo_cnt <= '0;
          state   <= BUSY;
        end
        BUSY: begin
          if (spi_done) begin
            rsp_data         <= spi_rdata;
            rsp_err          <= 1'b0;
            req_ack[gnt_idx] <= 1'b1;
            state            <= DONE;
          end else if (tmo_cnt == TMO_WTH'(TIMEOUT_CYC - 1)) begin
            rsp_data         <= '0;
            rsp_err          <= 1'b1;
            req_ack[gnt_idx] <= 1'b1;
            state            <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          ptr   <= (gnt_idx == REQ_WTH'(REQ_NUM - 1)) ? '0 : gnt_idx + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign spi_address  = cmd_q.addr;
  assign spi_data     = cmd_q.data;
  assign spi_data_num = cmd_q.num;
  assign spi_slv_sel  = cmd_q.slv;
  assign spi_mode     = {{(8 - MODE_W){1'b0}}, cmd_q.mode};
  assign spi_wr       = cmd_q.wr;

endmodule

// File: tb/tb_spi_req_sched.sv
// Self-checking bench for spi_req_sched: a cycle-indexed transaction model
// checked every cycle, plus directed literal checks including a short-timeout instance.
module tb_spi_req_sched;

  localparam int REQ_NUM = 4;
  localparam int TMO     = 64;
  localparam int TMO2    = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req_vld, req_vld2;
  logic [7:0] f_addr [4];
  logic [7:0] f_data [4];
  logic [7:0] f_num  [4];
  logic [7:0] f_slv  [4];
  logic [1:0] f_mode [4];
  logic       f_wr   [4];
  logic [31:0] req_addr, req_data, req_num, req_slv;
  logic [7:0]  req_mode;
  logic [3:0]  req_wr;
  logic        spi_done, spi_done2;
  logic [7:0]  spi_rdata, spi_rdata2;

  logic [3:0] req_ack, ack2;
  logic [7:0] rsp_data, rsp_data2;
  logic       rsp_err, rsp_err2;
  logic [1:0] gnt_idx, gnt2;
  logic       busy, busy2, spi_trg_start, trg2;
  logic [7:0] spi_address, spi_data, spi_data_num, spi_slv_sel, spi_mode;
  logic [7:0] addr2, data2, num2, slv2, mode2;
  logic       spi_wr, wr2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign req_addr = {f_addr[3], f_addr[2], f_addr[1], f_addr[0]};
  assign req_data = {f_data[3], f_data[2], f_data[1], f_data[0]};
  assign req_num  = {f_num[3], f_num[2], f_num[1], f_num[0]};
  assign req_slv  = {f_slv[3], f_slv[2], f_slv[1], f_slv[0]};
  assign req_mode = {f_mode[3], f_mode[2], f_mode[1], f_mode[0]};
  assign req_wr   = {f_wr[3], f_wr[2], f_wr[1], f_wr[0]};

  spi_req_sched #(.REQ_NUM(REQ_NUM), .ADDR_BYTE(1), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_addr(req_addr), .req_data(req_data),
    .req_num(req_num), .req_slv(req_slv), .req_mode(req_mode), .req_wr(req_wr),
    .req_ack(req_ack), .rsp_data(rsp_data), .rsp_err(rsp_err), .gnt_idx(gnt_idx),
    .busy(busy), .spi_trg_start(spi_trg_start), .spi_address(spi_address),
    .spi_data(spi_data), .spi_data_num(spi_data_num), .spi_slv_sel(spi_slv_sel),
    .spi_mode(spi_mode), .spi_wr(spi_wr), .spi_done(spi_done), .spi_rdata(spi_rdata)
  );

  spi_req_sched #(.REQ_NUM(REQ_NUM), .ADDR_BYTE(1), .TIMEOUT_CYC(TMO2)) dut_tmo (
    .clk(clk), .rst(rst), .req_vld(req_vld2), .req_addr(req_addr), .req_data(req_data),
    .req_num(req_num), .req_slv(req_slv), .req_mode(req_mode), .req_wr(req_wr),
    .req_ack(ack2), .rsp_data(rsp_data2), .rsp_err(rsp_err2), .gnt_idx(gnt2),
    .busy(busy2), .spi_trg_start(trg2), .spi_address(addr2),
    .spi_data(data2), .spi_data_num(num2), .spi_slv_sel(slv2),
    .spi_mode(mode2), .spi_wr(wr2), .spi_done(spi_done2), .spi_rdata(spi_rdata2)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int i, input logic [7:0] a, input logic [7:0] d,
                               input logic [7:0] n, input logic [7:0] s,
                               input logic [1:0] m, input logic w);
    f_addr[i] = a;
    f_data[i] = d;
    f_num[i]  = n;
    f_slv[i]  = s;
    f_mode[i] = m;
    f_wr[i]   = w;
  endtask

  // Returns at the falling edge of the trigger cycle, or after a bounded wait.
  task automatic waitTrg(input string name);
    int n = 0;
    @(negedge clk);
    while (spi_trg_start !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, " trigger"}, 64'(spi_trg_start), 64'd1);
  endtask

  task automatic doDone(input int delay, input logic [7:0] rdata);
    repeat (delay) @(posedge clk);
    #2 spi_done = 1'b1;
    spi_rdata = rdata;
    @(posedge clk);
    #2 spi_done = 1'b0;
  endtask

  // Reference model: everything is timed relative to the grant edge.
  int         m_k = 0, m_ptr = 0, m_owner = 0, m_gedge = -1, m_aedge = -1;
  bit         m_on = 1'b0, m_rstd = 1'b0;
  logic [3:0]  e_ack = '0;
  logic        e_busy = 1'b0, e_trg = 1'b0, e_err = 1'b0;
  logic [1:0]  e_gnt = '0;
  logic [40:0] e_cmd = '0;
  logic [7:0]  e_rdata = '0;

  always @(posedge clk) begin
    m_k++;
    if (rst) begin
      m_on = 1'b1; m_rstd = 1'b1; m_ptr = 0; m_gedge = -1; m_aedge = -1;
      e_ack = '0; e_busy = 1'b0; e_trg = 1'b0; e_err = 1'b0;
      e_gnt = '0; e_cmd = '0; e_rdata = '0;
    end else if (m_on) begin
      m_rstd = 1'b0;
      e_trg  = 1'b0;
      e_ack  = '0;
      if (m_gedge < 0) begin
        if (req_vld != 4'b0) begin
          m_owner = -1;
          for (int off = 0; off < REQ_NUM; off++)
            if (m_owner < 0 && req_vld[(m_ptr + off) % REQ_NUM]) m_owner = (m_ptr + off) % REQ_NUM;
          m_gedge = m_k;
          e_trg   = 1'b1;
          e_busy  = 1'b1;
          e_gnt   = m_owner[1:0];
          e_cmd   = {f_addr[m_owner], f_data[m_owner], f_num[m_owner], f_slv[m_owner],
                     6'b0, f_mode[m_owner], f_wr[m_owner]};
        end
      end else if (m_aedge >= 0) begin
        e_busy  = 1'b0;
        m_ptr   = (m_owner + 1) % REQ_NUM;
        m_gedge = -1;
        m_aedge = -1;
      end else if (m_k >= m_gedge + 2) begin
        if (spi_done) begin
          e_ack = 4'(1 << m_owner); e_rdata = spi_rdata; e_err = 1'b0; m_aedge = m_k;
        end else if (m_k == m_gedge + 1 + TMO) begin
          e_ack = 4'(1 << m_owner); e_rdata = 8'h00; e_err = 1'b1; m_aedge = m_k;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      checkOutput("model ack", 64'(req_ack), 64'(e_ack));
      checkOutput("model busy", 64'(busy), 64'(e_busy));
      checkOutput("model trg", 64'(spi_trg_start), 64'(e_trg));
      checkOutput("model gnt", 64'(gnt_idx), 64'(e_gnt));
      checkOutput("model cmd", 64'({spi_address, spi_data, spi_data_num, spi_slv_sel, spi_mode, spi_wr}),
                  64'(e_cmd));
      if (e_ack != 4'b0 || m_rstd) begin
        checkOutput("model rsp_data", 64'(rsp_data), 64'(e_rdata));
        checkOutput("model rsp_err", 64'(rsp_err), 64'(e_err));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int grants [5];
    int exp_gnt [5] = '{0, 1, 2, 3, 0};
    int n;
    spi_done = 1'b0; spi_done2 = 1'b0; spi_rdata = '0; spi_rdata2 = 8'h5A;
    req_vld = '0; req_vld2 = '0;
    for (int i = 0; i < REQ_NUM; i++)
      applyStimulus(i, 8'h10 + 8'(i), 8'h20 + 8'(i), 8'(i + 1), 8'(1 << i), 2'(i), i[0]);

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset ack", 64'(req_ack), 64'h0);
    checkOutput("reset busy", 64'(busy), 64'h0);
    checkOutput("reset trg", 64'(spi_trg_start), 64'h0);
    checkOutput("reset address", 64'(spi_address), 64'h0);
    checkOutput("reset mode", 64'(spi_mode), 64'h0);
    @(posedge clk);
    #2 rst = 1'b0;

    $display("[TB] single write request from requester 1");
    applyStimulus(1, 8'h3A, 8'h5C, 8'd1, 8'd1, 2'b01, 1'b1);
    req_vld = 4'b0010;
    @(posedge clk);
    @(negedge clk);
    checkOutput("single trg", 64'(spi_trg_start), 64'd1);
    checkOutput("single address", 64'(spi_address), 64'h3A);
    checkOutput("single mode", 64'(spi_mode), 64'h01);
    checkOutput("single gnt", 64'(gnt_idx), 64'd1);
    doDone(40, 8'h00);
    req_vld = 4'b0;
    @(negedge clk);
    checkOutput("single ack", 64'(req_ack), 64'b0010);
    checkOutput("single err", 64'(rsp_err), 64'd0);

    $display("[TB] all four requesting from pointer 0");
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    req_vld = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      waitTrg("rr");
      grants[t] = int'(gnt_idx);
      doDone(2, 8'h40 + 8'(t));
      if (t == 4) req_vld = 4'b0;
    end
    for (int t = 0; t < 5; t++)
      checkOutput($sformatf("rr grant %0d", t), 64'(grants[t]), 64'(exp_gnt[t]));

    $display("[TB] read from requester 3");
    applyStimulus(3, 8'h77, 8'h00, 8'd1, 8'd3, 2'b11, 1'b0);
    req_vld = 4'b1000;
    waitTrg("read");
    doDone(5, 8'hA7);
    req_vld = 4'b0;
    @(negedge clk);
    checkOutput("read ack", 64'(req_ack), 64'b1000);
    checkOutput("read data", 64'(rsp_data), 64'hA7);

    $display("[TB] timeout on main instance, then a normal request");
    req_vld = 4'b0001;
    waitTrg("tmo");
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (req_ack == 4'b0 && n < 200);
    req_vld = 4'b0;
    checkOutput("tmo cycles", 64'(n), 64'(TMO + 1));
    checkOutput("tmo err", 64'(rsp_err), 64'd1);
    checkOutput("tmo data", 64'(rsp_data), 64'h0);
    req_vld = 4'b0010;
    waitTrg("after tmo");
    doDone(3, 8'h11);
    req_vld = 4'b0;
    @(negedge clk);
    checkOutput("after tmo ack", 64'(req_ack), 64'b0010);
    checkOutput("after tmo err", 64'(rsp_err), 64'd0);

    $display("[TB] 16-cycle timeout instance");
    req_vld2 = 4'b0001;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (trg2 !== 1'b1 && n < 20);
    checkOutput("tmo16 trg", 64'(trg2), 64'd1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack2 == 4'b0 && n < 100);
    req_vld2 = 4'b0;
    checkOutput("tmo16 cycles", 64'(n), 64'd17);
    checkOutput("tmo16 ack", 64'(ack2), 64'b0001);
    checkOutput("tmo16 err", 64'(rsp_err2), 64'd1);
    checkOutput("tmo16 data", 64'(rsp_data2), 64'h0);
    req_vld2 = 4'b0010;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (trg2 !== 1'b1 && n < 20);
    checkOutput("tmo16 next trg", 64'(trg2), 64'd1);
    repeat (2) @(posedge clk);
    #2 spi_done2 = 1'b1;
    @(posedge clk);
    #2 spi_done2 = 1'b0;
    req_vld2 = 4'b0;
    @(negedge clk);
    checkOutput("tmo16 next ack", 64'(ack2), 64'b0010);
    checkOutput("tmo16 next err", 64'(rsp_err2), 64'd0);
    checkOutput("tmo16 next data", 64'(rsp_data2), 64'h5A);

    $display("[TB] requester 2 drops request mid-transaction, then stray done");
    applyStimulus(2, 8'hC2, 8'h9E, 8'd4, 8'h04, 2'b10, 1'b0);
    req_vld = 4'b0100;
    waitTrg("drop");
    checkOutput("drop gnt", 64'(gnt_idx), 64'd2);
    repeat (3) @(posedge clk);
    #2 req_vld = 4'b0;
    doDone(4, 8'h3C);
    @(negedge clk);
    checkOutput("drop ack", 64'(req_ack), 64'b0100);
    checkOutput("drop data", 64'(rsp_data), 64'h3C);
    repeat (3) @(posedge clk);
    #2 spi_done = 1'b1;
    @(posedge clk);
    #2 spi_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("stray ack", 64'(req_ack), 64'h0);
    end

    $display("[TB] reset during BUSY");
    req_vld = 4'b1000;
    waitTrg("rst");
    checkOutput("rst gnt before", 64'(gnt_idx), 64'd3);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    req_vld = 4'b1010;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst ack", 64'(req_ack), 64'h0);
    checkOutput("rst busy", 64'(busy), 64'h0);
    checkOutput("rst gnt", 64'(gnt_idx), 64'h0);
    checkOutput("rst address", 64'(spi_address), 64'h0);
    @(posedge clk);
    #2 rst = 1'b0;
    waitTrg("post rst");
    checkOutput("post rst gnt", 64'(gnt_idx), 64'd1);
    doDone(2, 8'h66);
    req_vld = 4'b1000;
    waitTrg("post rst 2");
    checkOutput("post rst gnt 2", 64'(gnt_idx), 64'd3);
    doDone(2, 8'h77);
    req_vld = 4'b0;
    @(negedge clk);
    checkOutput("post rst ack", 64'(req_ack), 64'b1000);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_req_sched.md
Name: spi_req_sched

Overview:
- Round-robin scheduler that shares one SPI master between REQ_NUM independent requesters, e.g. a sensor-config FSM, a debug register bridge and a calibration engine.
- Latches the winning request's command (address, data, byte count, slave select, mode, direction) and drives it as the master's register-side inputs.
- Pulses the master's trigger, waits for the master's final-toggle completion pulse, then returns read data and status to the requester with a one-cycle acknowledge.
- Sits between the requesters and spi_top; it is the only driver of the master's register-side inputs.

Parameters:
- REQ_NUM, 4, number of requesters; minimum 2.
- ADDR_BYTE, 1, address bytes per command; matches the master's MOSI_ADDR_BYTE.
- TIMEOUT_CYC, 65535, clk cycles to wait for completion before aborting with error.
- REQ_WTH, $clog2(REQ_NUM), width of the grant index.
- TMO_WTH, $clog2(TIMEOUT_CYC+1), width of the timeout counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req_vld  in  REQ_NUM  per-requester request; held until req_ack.
- req_addr  in  REQ_NUM*8*ADDR_BYTE  packed addresses; requester i occupies slice i.
- req_data  in  REQ_NUM*8  packed write data.
- req_num  in  REQ_NUM*8  packed byte counts.
- req_slv  in  REQ_NUM*8  packed slave selects.
- req_mode  in  REQ_NUM*2  packed {CPOL,CPHA}.
- req_wr  in  REQ_NUM  1 = write, 0 = read.
- req_ack  out  REQ_NUM  one-hot, one-cycle completion pulse.
- rsp_data  out  8  read byte; valid with req_ack.
- rsp_err  out  1  timeout flag; valid with req_ack.
- gnt_idx  out  REQ_WTH  index of the current owner.
- busy  out  1  high from grant through the ack cycle.
- spi_trg_start  out  1  trigger pulse to the master.
- spi_address  out  8*ADDR_BYTE  to the master's r_address.
- spi_data  out  8  to the master's r_data.
- spi_data_num  out  8  to the master's r_data_num.
- spi_slv_sel  out  8  to the master's r_slv_sel.
- spi_mode  out  8  to the master's r_spi_mode; bits [7:2] are always 0.
- spi_wr  out  1  to the master's r_spi_wr.
- spi_done  in  1  master's o_tgl_fnl completion pulse.
- spi_rdata  in  8  master's o_data_reg.

Behaviour:
- Reset:
  - State = IDLE; round-robin pointer = 0.
  - All outputs are registered and reset to 0: ack, rsp, gnt_idx, busy, and all spi_* outputs.
- FSM states are IDLE, START, BUSY and DONE.
- IDLE:
  - If any req_vld is set, pick the first set bit at or after the pointer, wrapping modulo REQ_NUM.
  - Latch that requester's fields into the spi_* registers, set gnt_idx, set busy, and go to START.
  - Otherwise stay in IDLE.
- START:
  - spi_trg_start = 1 for exactly this cycle.
  - Clear the timeout counter; go to BUSY.
- BUSY:
  - spi_done = 1: capture spi_rdata, clear the error flag, go to DONE.
  - Else if the counter == TIMEOUT_CYC-1: set the error flag and load rsp_data = 0, then go to DONE.
  - Else increment the counter.
  - spi_done arriving on the timeout cycle counts as success.
- DONE:
  - req_ack[gnt_idx] = 1 for one cycle; drive rsp_data and rsp_err.
  - Set pointer = gnt_idx+1, wrapping to 0 after REQ_NUM-1.
  - Clear busy; go to IDLE.
- Latency:
  - req_vld sampled in IDLE at cycle N → spi_trg_start high at N+1.
  - spi_done at cycle M → req_ack at M+1.
  - At least one IDLE cycle separates back-to-back transactions.
- Field stability:
  - spi_* command outputs hold from grant until the next grant; they are not cleared in IDLE.
  - Requester field changes after grant are ignored.
- req_vld dropped before ack: the transaction still completes and the ack is still issued, which the requester ignores. No abort path exists.
- spi_done outside BUSY is ignored.
- Simultaneous requests are resolved purely by pointer order; each requester waits at most REQ_NUM-1 transactions.
- rst asserted mid-transaction:
  - Returns to IDLE with all outputs 0; no ack is issued.
  - The master is reset by the same rst.
- req_num = 0 is passed through unchanged; handling it is the master's responsibility.

Decomposition:
- Package spi_sched_pkg holds:
  - the state enum (IDLE, START, BUSY, DONE);
  - the spi_cmd_t struct {addr, data, num, slv, mode, wr} parameterised by ADDR_BYTE via localparam width;
  - localparam MODE_W = 2.
- One sub-module, spi_rr_arb: combinational round-robin priority picker taking a REQ_NUM-wide request vector and the pointer, returning an index and an any-request flag.

Test Plan:
- Single request:
  - Stimulus: req_vld = 4'b0010; addr 0x3A, data 0x5C, num 1, slv 1, mode 2'b01, wr 1.
  - Required: trg_start one cycle later; spi_address = 0x3A, spi_mode = 0x01.
  - Stimulus: spi_done after 40 cycles.
  - Required: req_ack = 4'b0010 next cycle, rsp_err = 0.
- All four requesting continuously, pointer = 0:
  - Required: grants 0, 1, 2, 3, 0 in order; no requester is granted twice before all others are served.
- Read:
  - Stimulus: req_wr = 0, spi_rdata = 0xA7 at spi_done.
  - Required: rsp_data = 0xA7 with the ack.
- Timeout:
  - Stimulus: TIMEOUT_CYC = 16, spi_done never asserted.
  - Required: ack 17 cycles after trg_start with rsp_err = 1 and rsp_data = 0; the next request is then served normally.
- Requester 2 drops req_vld mid-BUSY:
  - Required: the transaction completes and req_ack[2] pulses.
  - Stimulus: a stray spi_done in IDLE.
  - Required: no ack.
- rst pulsed during BUSY:
  - Required: all outputs 0 next cycle, no ack.
  - Required: a pending request is re-arbitrated from pointer 0.
